aux_native: RTL and testbench
=============================

AUX_NATIVE -- requirements
Module: aux_native

Interface
REQ-001 Parameter TIMEOUT, 16'd4000, clk cycles allowed from last request byte accepted to first reply byte.
REQ-002 Parameter DEFERGAP, 16'd400, idle clk cycles between a DEFER reply and the retry.
REQ-003 Parameter RETRIES, 7, maximum resends after DEFER replies.
REQ-004 clk  in  1  sole clock; all logic on posedge clk.
REQ-005 resetn  in  1  reset, synchronous, active-low.
REQ-006 auxaddr  in  20  DPCD address of the request.
REQ-007 auxwdata  in  8  write byte.
REQ-008 auxwr  in  1  1 = native write, 0 = native read.
REQ-009 auxreq  in  1  level request; held by the initiator until auxack, then dropped.
REQ-010 auxack  out  1  one-cycle completion pulse.
REQ-011 auxerr  out  1  valid with auxack; 1 = transaction failed.
REQ-012 auxrdata  out  8  read byte, valid with auxack.
REQ-013 txdata  out  8  request byte to the AUX line encoder.
REQ-014 txvalid  out  1  txdata valid.
REQ-015 txlast  out  1  marks the final byte of the request.
REQ-016 txready  in  1  encoder accepts a byte when txvalid && txready.
REQ-017 rxdata  in  8  reply byte from the AUX line decoder.
REQ-018 rxvalid  in  1  one-cycle strobe per reply byte.
REQ-019 rxlast  in  1  with rxvalid, marks the last byte of the reply.
REQ-020 rxerr  in  1  one-cycle strobe for a decoder framing/sync error.

Function
REQ-021 States: IDLE, SEND, WAIT, RECV, GAP, DONE, RELEASE.
REQ-022 IDLE && auxreq: latch addr, wdata and wr; clear the retry count; go to SEND.
REQ-023 SEND emits in order: {wr?4'b1000:4'b1001, addr[19:16]}, addr[15:8], addr[7:0], 8'h00 (length-1), then wdata for writes only; txlast is set on the final byte.
REQ-024 txvalid/txdata/txlast hold stable until accepted; a byte advances only on txvalid && txready; no bubble is required between bytes.
REQ-025 Acceptance of the last byte starts the timeout counter at 0 and moves to WAIT.
REQ-026 In WAIT, the counter reaching TIMEOUT without rxvalid gives DONE with err=1.
REQ-027 First reply byte, bits[5:4]: 00 ACK, 01 NACK, 10 DEFER, 11 treated as NACK; bits[7:6] and [3:0] are ignored.
REQ-028 ACK on a write gives DONE with err=0 and rdata=0; any further bytes are discarded.
REQ-029 ACK on a read with rxlast=0 goes to RECV; the next rxvalid byte becomes rdata, then DONE with err=0.
REQ-030 ACK on a read with rxlast=1 (no data) gives DONE with err=1.
REQ-031 NACK gives DONE with err=1.
REQ-032 DEFER with retry count < RETRIES: increment the count and go to GAP.
REQ-033 DEFER with count == RETRIES gives DONE with err=1.
REQ-034 GAP waits DEFERGAP cycles, then returns to SEND with the same latched request.
REQ-035 rxerr in WAIT or RECV gives DONE with err=1.
REQ-036 rxvalid/rxerr in IDLE, SEND, GAP, DONE or RELEASE are ignored.
REQ-037 A reply is consumed only up to the byte needed; later bytes of the same reply are ignored until rxlast.
REQ-038 DONE: auxack=1 for exactly one cycle with auxerr/auxrdata; then RELEASE.
REQ-039 auxrdata and auxerr hold their values until the next DONE.
REQ-040 RELEASE waits for auxreq==0, then IDLE; a held auxreq never starts a second transaction.
REQ-041 auxaddr/auxwdata/auxwr changes after the latch in IDLE have no effect on the current transaction.
REQ-042 Transaction latency is unbounded (set by txready/reply); the block imposes no extra cycle between the reply byte and auxack beyond one register stage.

Reset
REQ-043 resetn low at a clock edge: state IDLE; auxack=0, auxerr=0, auxrdata=0, txvalid=0, txlast=0, txdata=0; counters cleared.
REQ-044 Reset mid-transaction abandons it with no auxack; after release, an auxreq still high starts a fresh transaction.

Verification
REQ-045 Read 0x00101, reply bytes 0x00 then 0x3C -> tx bytes 0x90,0x01,0x01,0x00 (txlast on 4th); one auxack, auxerr=0, auxrdata=0x3C.
REQ-046 Write 0x5A to 0x00600 with txready toggling -> tx bytes 0x80,0x06,0x00,0x00,0x5A, each held until accepted; reply 0x00 -> auxack, auxerr=0, auxrdata=0.
REQ-047 Read with DEFER (0x20) replied 8 times -> exactly 8 request packets, each ≥DEFERGAP cycles after the prior DEFER; auxack with auxerr=1.
REQ-048 Read with DEFER twice then ACK+0x11 -> 3 packets; auxerr=0, auxrdata=0x11.
REQ-049 No reply (TIMEOUT=100) -> auxack with auxerr=1 exactly 100 cycles after the last byte accepted; NACK 0x10 -> auxerr=1.
REQ-050 auxreq held 20 cycles after auxack -> no new tx bytes; resetn low during SEND -> txvalid=0 next cycle, no auxack.

Source files
------------

// File: rtl/aux_native.sv
// aux_native: DisplayPort AUX native read/write requester with DEFER retry, reply timeout and request handshake
module aux_native #(
  parameter logic [15:0] TIMEOUT = 16'd4000,
  parameter logic [15:0] DEFERGAP = 16'd400,
  parameter logic [7:0] RETRIES = 8'd7
) (
  input logic clk,
  input logic resetn,
  input logic [19:0] auxaddr,
  input logic [7:0] auxwdata,
  input logic auxwr,
  input logic auxreq,
  output logic auxack,
  output logic auxerr,
  output logic [7:0] auxrdata,
  output logic [7:0] txdata,
  output logic txvalid,
  output logic txlast,
  input logic txready,
  input logic [7:0] rxdata,
  input logic rxvalid,
  input logic rxlast,
  input logic rxerr
);
  localparam logic [2:0] IDLE = 3'd0, SEND = 3'd1, WAIT = 3'd2, RECV = 3'd3, GAP = 3'd4, DONE = 3'd5, RELEASE = 3'd6;
  logic [2:0] state, idx;
  logic [15:0] cnt;
  logic [7:0] retry, wdata, frd;
  logic [19:0] addr;
  logic wr, skip, rx, fin, ferr, go_recv, go_gap, busy;
  logic [1:0] rep;
  assign txvalid = state == SEND;
  assign txlast = txvalid && idx == (wr ? 3'd4 : 3'd3);
  assign txdata = !txvalid ? 8'h00 : idx == 3'd0 ? {wr ? 4'b1000 : 4'b1001, addr[19:16]} :
                  idx == 3'd1 ? addr[15:8] : idx == 3'd2 ? addr[7:0] : idx == 3'd3 ? 8'h00 : wdata;
  assign rx = rxvalid && !skip;
  assign rep = rxdata[5:4];
  assign busy = state == WAIT || state == RECV;
  always_comb begin
    fin = 1'b0;
    ferr = 1'b1;
    frd = 8'h00;
    go_recv = 1'b0;
    go_gap = 1'b0;
    if (busy) begin
      if (rxerr) fin = 1'b1;
      else if (rx && state == RECV) begin
        fin = 1'b1;
        ferr = 1'b0;
        frd = rxdata;
      end else if (rx) begin
        go_recv = rep == 2'b00 && !wr && !rxlast;
        go_gap = rep == 2'b10 && retry < RETRIES;
        fin = !go_recv && !go_gap;
        ferr = !(rep == 2'b00 && wr);
      end else fin = state == WAIT && cnt == TIMEOUT - 16'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      idx <= 3'd0;
      cnt <= 16'd0;
      retry <= 8'd0;
      addr <= 20'd0;
      wdata <= 8'h00;
      wr <= 1'b0;
      skip <= 1'b0;
      auxack <= 1'b0;
      auxerr <= 1'b0;
      auxrdata <= 8'h00;
    end else begin
      skip <= (rxerr || (rxvalid && rxlast)) ? 1'b0 : (rx && busy && !go_recv) ? 1'b1 : skip;
      auxack <= fin;
      if (fin) begin
        auxerr <= ferr;
        auxrdata <= frd;
      end
      case (state)
        IDLE: if (auxreq) begin
          addr <= auxaddr;
          wdata <= auxwdata;
          wr <= auxwr;
          retry <= 8'd0;
          idx <= 3'd0;
          state <= SEND;
        end
        SEND: if (txready) begin
          idx <= idx + 3'd1;
          cnt <= 16'd0;
          state <= txlast ? WAIT : SEND;
        end
        WAIT: begin
          cnt <= go_gap ? 16'd0 : cnt + 16'd1;
          retry <= go_gap ? retry + 8'd1 : retry;
          state <= fin ? DONE : go_recv ? RECV : go_gap ? GAP : WAIT;
        end
        RECV: state <= fin ? DONE : RECV;
        GAP: if (cnt == DEFERGAP - 16'd1) begin
          idx <= 3'd0;
          state <= SEND;
        end else cnt <= cnt + 16'd1;
        DONE: state <= RELEASE;
        RELEASE: state <= auxreq ? RELEASE : IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aux_native.sv
// tb_aux_native: randomized transaction-level check of aux_native against a packet/outcome model
module tb_aux_native;
  localparam int TMO = 100, GAPC = 20, RET = 7;
  logic clk, resetn, auxreq, auxwr, auxack, auxerr, txvalid, txlast, txready, rxvalid, rxlast, rxerr;
  logic [19:0] auxaddr;
  logic [7:0] auxwdata, auxrdata, txdata, rxdata;
  int cyc, pkts, acks, bidx, ack_cyc, last_acc, rx_cyc, checks, passes, tr_mode;
  logic [9:0] got[$];
  int firsts[$];
  logic hold_pend;
  logic [9:0] hold_val;
  aux_native #(.TIMEOUT(16'(TMO)), .DEFERGAP(16'(GAPC)), .RETRIES(8'(RET))) dut (
    .clk(clk), .resetn(resetn), .auxaddr(auxaddr), .auxwdata(auxwdata), .auxwr(auxwr),
    .auxreq(auxreq), .auxack(auxack), .auxerr(auxerr), .auxrdata(auxrdata), .txdata(txdata),
    .txvalid(txvalid), .txlast(txlast), .txready(txready), .rxdata(rxdata), .rxvalid(rxvalid),
    .rxlast(rxlast), .rxerr(rxerr)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #2;
  endtask
  always @(negedge clk) begin
    if (!resetn) begin
      bidx = 0;
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) chk("tx_hold", 32'({txvalid, txlast, txdata}), 32'(hold_val));
      hold_pend = txvalid && !txready;
      hold_val = {txvalid, txlast, txdata};
      if (rxvalid || rxerr) rx_cyc = cyc + 1;
      if (auxack) begin
        acks++;
        ack_cyc = cyc;
      end
      if (txvalid && txready) begin
        got.push_back({1'b0, txlast, txdata});
        if (bidx == 0) firsts.push_back(cyc + 1);
        bidx = txlast ? 0 : bidx + 1;
        if (txlast) begin
          pkts++;
          last_acc = cyc + 1;
        end
      end
    end
  end
  initial begin
    txready = 1'b0;
    forever begin
      step;
      txready = tr_mode == 0 ? 1'b1 : tr_mode == 1 ? 1'($urandom) : 1'b0;
    end
  end
  task automatic rx_byte(input logic [7:0] d, input logic l);
    repeat ($urandom_range(0, 3)) step;
    rxdata = d;
    rxlast = l;
    rxvalid = 1'b1;
    step;
    rxvalid = 1'b0;
    rxlast = 1'b0;
  endtask
  // kind: 0 ack (+data on read), 1 nack, 2 no reply, 3 rxerr, 4 ack without data, 5 reply type 11
  task automatic txn(input logic [19:0] a, input logic [7:0] wd, input logic w, input int ndef,
                     input int kind, input logic [7:0] rd, input int hold);
    int np, p0, a0, n, tmo;
    int dat[$];
    logic [9:0] exp_q[$];
    logic exp_err, l, trail;
    np = ndef > RET ? RET + 1 : ndef + 1;
    exp_err = ndef > RET || !(kind == 0 || (kind == 4 && w));
    tmo = kind == 2 && ndef <= RET;
    trail = 1'b0;
    for (int p = 0; p < np; p++) begin
      exp_q.push_back({2'b00, w ? 4'h8 : 4'h9, a[19:16]});
      exp_q.push_back({2'b00, a[15:8]});
      exp_q.push_back({2'b00, a[7:0]});
      exp_q.push_back({1'b0, !w, 8'h00});
      if (w) exp_q.push_back({2'b01, wd});
    end
    got.delete();
    firsts.delete();
    p0 = pkts;
    a0 = acks;
    auxaddr = a;
    auxwdata = wd;
    auxwr = w;
    auxreq = 1'b1;
    for (int p = 0; p < np; p++) begin
      n = 0;
      while (pkts < p0 + p + 1 && n < 1000) begin
        step;
        n++;
      end
      if (pkts < p0 + p + 1) begin
        chk("pkt_wait", pkts - p0, p + 1);
        break;
      end
      auxaddr = 20'($urandom);
      auxwdata = 8'($urandom);
      auxwr = 1'($urandom);
      if (p > 0 && p <= ndef) chk("defer_gap", 32'(firsts[p] - dat[p-1] >= GAPC), 1);
      if (p < ndef) begin
        rx_byte({2'($urandom), 2'b10, 4'($urandom)}, 1'b1);
        dat.push_back(rx_cyc);
      end else if (kind == 0 || kind == 4) begin
        l = kind == 4 ? 1'b1 : w ? 1'($urandom) : 1'b0;
        rx_byte({2'($urandom), 2'b00, 4'($urandom)}, l);
        trail = !l && w;
        if (kind == 0 && !w) begin
          l = 1'($urandom);
          rx_byte(rd, l);
          trail = !l;
        end
      end else if (kind == 1) rx_byte({2'($urandom), 2'b01, 4'($urandom)}, 1'b1);
      else if (kind == 5) rx_byte({2'($urandom), 2'b11, 4'($urandom)}, 1'b1);
      else if (kind == 3) begin
        repeat ($urandom_range(0, 3)) step;
        rxerr = 1'b1;
        step;
        rxerr = 1'b0;
      end
    end
    n = 0;
    while (acks == a0 && n < 400) begin
      step;
      n++;
    end
    chk("ack_count", acks - a0, 1);
    chk("pkt_count", pkts - p0, np);
    chk("auxerr", auxerr, exp_err);
    if (!exp_err) chk("auxrdata", auxrdata, w ? 8'h00 : rd);
    chk("ack_latency", ack_cyc - (tmo ? last_acc : rx_cyc), tmo ? TMO : 0);
    if (trail) rx_byte(8'($urandom), 1'b1);
    chk("tx_len", got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk("tx_byte", got[i], exp_q[i]);
    repeat (hold) step;
    chk("held_no_tx", got.size(), exp_q.size());
    chk("one_ack", acks - a0, 1);
    chk("err_hold", auxerr, exp_err);
    auxreq = 1'b0;
    repeat (2) step;
  endtask
  initial begin
    int nd, k, a0;
    checks = 0;
    passes = 0;
    pkts = 0;
    acks = 0;
    tr_mode = 0;
    resetn = 1'b0;
    auxreq = 1'b0;
    auxaddr = 20'd0;
    auxwdata = 8'h00;
    auxwr = 1'b0;
    rxdata = 8'h00;
    rxvalid = 1'b0;
    rxlast = 1'b0;
    rxerr = 1'b0;
    repeat (3) step;
    chk("rst_auxack", auxack, 0);
    chk("rst_auxerr", auxerr, 0);
    chk("rst_auxrdata", auxrdata, 0);
    chk("rst_txvalid", txvalid, 0);
    chk("rst_txlast", txlast, 0);
    chk("rst_txdata", txdata, 0);
    resetn = 1'b1;
    step;
    txn(20'h00101, 8'h00, 1'b0, 0, 0, 8'h3C, 2);
    tr_mode = 1;
    txn(20'h00600, 8'h5A, 1'b1, 0, 0, 8'h00, 2);
    tr_mode = 0;
    txn(20'h00101, 8'h00, 1'b0, 8, 0, 8'h77, 2);
    txn(20'h00200, 8'h00, 1'b0, 2, 0, 8'h11, 2);
    txn(20'h00300, 8'h00, 1'b0, 0, 2, 8'h00, 2);
    txn(20'h00310, 8'h00, 1'b0, 0, 1, 8'h00, 2);
    txn(20'h00320, 8'h99, 1'b1, 0, 0, 8'h00, 20);
    txn(20'h00330, 8'h00, 1'b0, 0, 4, 8'h00, 2);
    tr_mode = 2;
    a0 = acks;
    auxaddr = 20'hABCDE;
    auxwr = 1'b0;
    auxreq = 1'b1;
    repeat (4) step;
    chk("send_txvalid", txvalid, 1);
    resetn = 1'b0;
    step;
    chk("midrst_txvalid", txvalid, 0);
    chk("midrst_txlast", txlast, 0);
    chk("midrst_auxack", auxack, 0);
    chk("midrst_auxerr", auxerr, 0);
    resetn = 1'b1;
    tr_mode = 0;
    chk("midrst_noack", acks - a0, 0);
    txn(20'hABCDE, 8'h00, 1'b0, 0, 0, 8'h42, 2);
    for (int i = 0; i < 30; i++) begin
      tr_mode = int'($urandom_range(0, 1));
      nd = $urandom_range(0, 2) == 0 ? int'($urandom_range(1, 9)) : 0;
      k = int'($urandom_range(0, 5));
      if (k == 2 && $urandom_range(0, 1) == 1) k = 0;
      txn(20'($urandom), 8'($urandom), 1'($urandom), nd, k, 8'($urandom), int'($urandom_range(1, 4)));
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
